auth_proxy_arbiter: RTL and testbench

//  Multi-channel authorising proxy: NUM_CH requesters push tagged beats (data + destination ID).

---
 rtl/auth_proxy_arbiter_pkg.sv | 15 +
 rtl/auth_proxy_arbiter_chan_fifo.sv | 52 +++++
 rtl/auth_proxy_arbiter.sv | 116 +++++++++++
 tb/tb_auth_proxy_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/auth_proxy_arbiter_pkg.sv
// Shared defaults and helpers for the authorising proxy arbiter.
package auth_proxy_arbiter_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DEST_W = 2;
  localparam int DEF_CNT_W  = 8;

  // Saturating accumulate used by the deny counter; never wraps past limit.
  function automatic int sat_add(input int acc, input int inc, input int limit);
    return (acc + inc > limit) ? limit : acc + inc;
  endfunction

endpackage

// File: rtl/auth_proxy_arbiter_chan_fifo.sv
// Per-channel beat FIFO with count-based full/empty flags.
module proxy_chan_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/auth_proxy_arbiter.sv
// Authorising proxy: per-channel permission check, channel FIFOs, round-robin merge.
module auth_proxy_arbiter
  import auth_proxy_arbiter_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int DEST_W = DEF_DEST_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int NDEST  = 1 << DEST_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*WIDTH-1:0]  in_data,
  input  logic [NUM_CH*DEST_W-1:0] in_dest,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [NDEST-1:0]         cfg_mask,
  output logic [WIDTH-1:0]         out_data,
  output logic [DEST_W-1:0]        out_dest,
  output logic [CH_W-1:0]          out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        deny_pulse,
  output logic [CNT_W-1:0]         deny_count
);

  localparam int BW      = WIDTH + DEST_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [(1<<CH_W)-1:0] CH_EXISTS = {(1<<CH_W){1'b1}} >> ((1<<CH_W) - NUM_CH);

  logic [NDEST-1:0]  mask [NUM_CH];
  logic [BW-1:0]     fifo_q [NUM_CH];
  logic [NUM_CH-1:0] full, empty, taken, permit, push, pop, deny;
  logic [CH_W-1:0]   rr_ptr, gnt, cand;
  logic              load, found;
  int                deny_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    proxy_chan_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata ({in_dest[g*DEST_W +: DEST_W], in_data[g*WIDTH +: WIDTH]}),
      .rdata (fifo_q[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  assign in_ready = ~full;

  // Denied beats still consume a handshake; they just never enter a FIFO.
  always_comb begin
    permit = '0;
    deny_n = 0;
    taken  = in_valid & in_ready;
    for (int c = 0; c < NUM_CH; c++) begin
      permit[c] = mask[c][in_dest[c*DEST_W +: DEST_W]];
    end
    push = taken & permit;
    deny = taken & ~permit;
    for (int c = 0; c < NUM_CH; c++) begin
      deny_n += int'(deny[c]);
    end
  end

  // rr_ptr holds the first channel to search, i.e. last grant + 1.
  always_comb begin
    load  = !out_valid || out_ready;
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    pop   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    if (load && found) pop[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_dest   <= '0;
      out_src    <= '0;
      rr_ptr     <= '0;
      deny_pulse <= '0;
      deny_count <= '0;
      for (int c = 0; c < NUM_CH; c++) mask[c] <= '0;
    end else begin
      if (load) begin
        out_valid <= found;
        if (found) begin
          {out_dest, out_data} <= fifo_q[gnt];
          out_src <= gnt;
          rr_ptr  <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
        end
      end
      deny_pulse <= deny;
      deny_count <= CNT_W'(sat_add(int'(deny_count), deny_n, CNT_MAX));
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && CH_EXISTS[cfg_ch] && cfg_ch == CH_W'(c)) mask[c] <= cfg_mask;
      end
    end
  end

endmodule

// File: tb/tb_auth_proxy_arbiter.sv
// Randomised bench for auth_proxy_arbiter against a queue-based reference model.
module tb_auth_proxy_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_CH  = 4;
  localparam int DEPTH   = 4;
  localparam int DEST_W  = 2;
  localparam int CNT_W   = 8;
  localparam int CH_W    = 2;
  localparam int NDEST   = 4;
  localparam int CNT_MAX = 255;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*WIDTH-1:0]  in_data;
  logic [NUM_CH*DEST_W-1:0] in_dest;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic                     cfg_we;
  logic [CH_W-1:0]          cfg_ch;
  logic [NDEST-1:0]         cfg_mask;
  logic [WIDTH-1:0]         out_data;
  logic [DEST_W-1:0]        out_dest;
  logic [CH_W-1:0]          out_src;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH-1:0]        deny_pulse;
  logic [CNT_W-1:0]         deny_count;

  auth_proxy_arbiter #(
    .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DEST_W(DEST_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mask(cfg_mask),
    .out_data(out_data), .out_dest(out_dest), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .deny_pulse(deny_pulse), .deny_count(deny_count)
  );

  always #5 clk = ~clk;

  logic [DEST_W+WIDTH-1:0] mq [NUM_CH][$];
  logic [NDEST-1:0]        m_mask [NUM_CH];
  logic                    m_ov;
  logic [WIDTH-1:0]        m_data;
  logic [DEST_W-1:0]       m_dest;
  int                      m_src;
  int                      m_next;
  logic [NUM_CH-1:0]       m_pulse;
  int                      m_count;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // One clock edge of the reference: arbitration sees the FIFO contents from
  // before this edge's pushes, and a config write only affects later beats.
  task automatic modelStep();
    int sz [NUM_CH];
    int n;
    int c;
    logic [DEST_W-1:0] d;
    logic [DEST_W+WIDTH-1:0] beat;
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mq[k].delete();
        m_mask[k] = '0;
      end
      m_ov = 1'b0; m_data = '0; m_dest = '0; m_src = 0;
      m_next = 0; m_pulse = '0; m_count = 0;
      return;
    end
    for (int k = 0; k < NUM_CH; k++) sz[k] = mq[k].size();
    if (!m_ov || out_ready) begin
      m_ov = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_next + k) % NUM_CH;
        if (!m_ov && sz[c] > 0) begin
          beat   = mq[c].pop_front();
          m_data = beat[WIDTH-1:0];
          m_dest = beat[DEST_W+WIDTH-1:WIDTH];
          m_src  = c;
          m_next = (c + 1) % NUM_CH;
          m_ov   = 1'b1;
        end
      end
    end
    n = 0;
    m_pulse = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_valid[k] && sz[k] < DEPTH) begin
        d = in_dest[k*DEST_W +: DEST_W];
        if (m_mask[k][d]) mq[k].push_back({d, in_data[k*WIDTH +: WIDTH]});
        else begin
          m_pulse[k] = 1'b1;
          n++;
        end
      end
    end
    m_count = (m_count + n > CNT_MAX) ? CNT_MAX : m_count + n;
    if (cfg_we && int'(cfg_ch) < NUM_CH) m_mask[cfg_ch] = cfg_mask;
  endtask

  task automatic compareAll();
    logic [NUM_CH-1:0] rdy;
    for (int k = 0; k < NUM_CH; k++) rdy[k] = (mq[k].size() < DEPTH);
    checkOutput("out_valid", out_valid, m_ov);
    if (m_ov) begin
      checkOutput("out_data", out_data, m_data);
      checkOutput("out_dest", out_dest, m_dest);
      checkOutput("out_src", out_src, m_src);
    end
    checkOutput("in_ready", in_ready, rdy);
    checkOutput("deny_pulse", deny_pulse, m_pulse);
    checkOutput("deny_count", deny_count, m_count);
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleInputs();
    in_valid = '0; cfg_we = 1'b0; out_ready = 1'b1;
  endtask

  // valid_en selects which channels may request; cfg_rate is 1-in-N odds of a config write.
  task automatic applyStimulus(input logic [NUM_CH-1:0] valid_en, input int ready_pct, input int cfg_rate);
    for (int k = 0; k < NUM_CH; k++) begin
      in_data[k*WIDTH +: WIDTH]   = $urandom();
      in_dest[k*DEST_W +: DEST_W] = DEST_W'($urandom_range(0, NDEST-1));
    end
    in_valid  = valid_en & NUM_CH'($urandom());
    out_ready = ($urandom_range(0, 99) < ready_pct);
    cfg_we    = (cfg_rate > 0) && ($urandom_range(1, cfg_rate) == 1);
    cfg_ch    = CH_W'($urandom_range(0, NUM_CH-1));
    cfg_mask  = NDEST'($urandom());
  endtask

  task automatic writeAllMasks(input logic [NDEST-1:0] m);
    idleInputs();
    for (int k = 0; k < NUM_CH; k++) begin
      cfg_we = 1'b1; cfg_ch = CH_W'(k); cfg_mask = m;
      runCycle();
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_dest = '0; cfg_ch = '0; cfg_mask = '0;
    idleInputs();
    runCycle();
    runCycle();
    reset = 1'b0;

    // Deny-all after reset.
    in_valid = 4'b0001; in_dest = 8'b0000_0001;
    runCycle();
    checkOutput("first_deny_count", deny_count, 1);
    idleInputs();
    runCycle();

    // Permit ch0 -> dest1, then send one beat and let it emerge.
    cfg_we = 1'b1; cfg_ch = '0; cfg_mask = 4'b0010;
    runCycle();
    cfg_we = 1'b0; in_valid = 4'b0001; in_dest = 8'b0000_0001; in_data[WIDTH-1:0] = 32'hA5A5_0001;
    runCycle();
    in_valid = '0;
    runCycle();
    checkOutput("latency_src0_data", out_data, 32'hA5A5_0001);
    for (int i = 0; i < 3; i++) runCycle();

    for (int i = 0; i < 300; i++) begin
      applyStimulus(4'hF, 70, 8);
      runCycle();
    end

    // Backpressure fills ch2 while the output is stalled.
    writeAllMasks(4'hF);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0100, 0, 0);
      in_valid = 4'b0100;
      runCycle();
    end
    for (int i = 0; i < 8; i++) begin
      idleInputs();
      runCycle();
    end

    // Simultaneous bursts on all channels exercise round-robin order.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'hF, 100, 0);
      in_valid = 4'hF;
      runCycle();
    end
    for (int i = 0; i < 16; i++) begin
      idleInputs();
      runCycle();
    end

    // Same-cycle config: old mask allows ch1 dest0, new mask blocks the next beat.
    idleInputs();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mask = 4'b0001;
    runCycle();
    cfg_mask = 4'b0000; in_valid = 4'b0010; in_dest = 8'b0000_0000;
    runCycle();
    cfg_we = 1'b0;
    runCycle();
    in_valid = '0;
    for (int i = 0; i < 4; i++) runCycle();

    // Deny storm drives the counter into saturation.
    writeAllMasks(4'h0);
    for (int i = 0; i < 75; i++) begin
      applyStimulus(4'hF, 100, 0);
      in_valid = 4'hF;
      runCycle();
    end
    checkOutput("deny_saturated", deny_count, CNT_MAX);

    // Reset in the middle of traffic.
    writeAllMasks(4'hF);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'hF, 40, 0);
      runCycle();
    end
    reset = 1'b1;
    runCycle();
    checkOutput("reset_out_valid", out_valid, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(4'hF, 70, 4);
      runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
